multicycle_ctrl: RTL
====================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-high. Ports: clk  in  1  core clock (rising edge).
REQ-002 SHALL have rst  in  1  asynchronous active-high reset.
REQ-003 SHALL have instr  in  32  instruction (fetched word on imem_ready, IR contents otherwise).
REQ-004 SHALL have imem_req  out  1 and imem_ready  in  1  instruction-fetch handshake.
REQ-005 SHALL have dmem_req  out  1, dmem_we  out  1 and dmem_ready  in  1  data-memory handshake.
REQ-006 SHALL have br_taken  in  1  branch comparator result, valid in EXEC.
REQ-007 SHALL have ir_we  out  1, pc_we  out  1 and rf_we  out  1  register enables.
REQ-008 SHALL have imm_sel  out  3  immediate type: U=0, J=1, B=2, I=3, S=4, none=7.
REQ-009 SHALL have pc_sel  out  2  PC source: 0 pc+4, 1 pc+imm, 2 (rs1+imm)&~1.
REQ-010 SHALL have wb_sel  out  2  write-back source: 0 ALU, 1 load data, 2 pc+4.
REQ-011 SHALL have alu_src_b  out  1  ALU B operand: 0 rs2, 1 immediate.
REQ-012 SHALL have retire  out  1, illegal  out  1 and state  out  3 (debug).

Function
REQ-013 SHALL implement FSM states FETCH, DECODE, EXEC, MEM, WB, TRAP.
REQ-014 FETCH: imem_req=1 held until imem_ready; on imem_ready ir_we=1 (same cycle), next DECODE; imem_ready without imem_req ignored.
REQ-015 DECODE: classify instr[6:0]; the nine RV32I opcodes LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP are legal; any other opcode goes to TRAP.
REQ-016 imm_sel from DECODE through WB: LUI/AUIPC U; JAL J; JALR/LOAD/OP-IMM I; BRANCH B; STORE S; OP none(7).
REQ-017 alu_src_b=1 for all opcodes except OP and BRANCH.
REQ-018 EXEC, BRANCH: pc_we=1, pc_sel=br_taken?1:0, retire=1, next FETCH.
REQ-019 EXEC, LOAD/STORE: next MEM; all other legal opcodes: next WB.
REQ-020 MEM: dmem_req=1 held until dmem_ready; dmem_we=1 for STORE only; on dmem_ready, STORE: pc_we=1, pc_sel=0, retire=1, next FETCH; LOAD: next WB.
REQ-021 WB: rf_we=(instr[11:7]!=0), pc_we=1, retire=1, next FETCH; pc_sel 1 for JAL, 2 for JALR, 0 otherwise; wb_sel 1 for LOAD, 2 for JAL/JALR, 0 otherwise.
REQ-022 TRAP: illegal=1 sticky, all request/enable outputs 0, no exit except rst.
REQ-023 Latency (zero-wait memory): OP/OP-IMM/LUI/AUIPC/JAL/JALR 4 cycles, STORE 4, LOAD 5, BRANCH 3; each memory wait cycle adds 1.
REQ-024 retire SHALL pulse exactly one cycle per completed instruction, coincident with pc_we.
REQ-025 Outputs not named active for a state SHALL be 0 (imm_sel 7, sel fields 0).

Reset
REQ-026 rst asserted SHALL force FETCH asynchronously: imem_req=1 after release; all other outputs 0, imm_sel=7, illegal=0, state=FETCH encoding 0.
REQ-027 rst mid-MEM or mid-FETCH SHALL drop dmem_req/imem_req in the same cycle, without waiting for ready.

Structure
REQ-028 rv_pkg SHALL hold the opcode constants, the imm_sel/pc_sel/wb_sel encodings and the state enum; the immediate generator and this controller share the imm_sel encoding.
REQ-029 One combinational sub-module, opcode_decode (opcode -> class, legal), SHALL be instantiated; the FSM stays in multicycle_ctrl.

Verification
REQ-030 ADDI x1,x0,5 (0x00500093), ready=1 -> imm_sel=3, alu_src_b=1, rf_we=1 and retire in cycle 4, wb_sel=0.
REQ-031 LW x2,0(x1) (0x0000A103), dmem_ready delayed 2 cycles -> dmem_req held 3 cycles, dmem_we=0, rf_we with wb_sel=1 at cycle 7.
REQ-032 BEQ x0,x0,8 (0x00000463), br_taken=1 -> imm_sel=2, pc_sel=1, pc_we/retire in cycle 3, rf_we never 1.
REQ-033 JALR x1,0(x1) (0x000080E7) -> imm_sel=3, pc_sel=2, wb_sel=2, rf_we=1 in WB.
REQ-034 Word 0xFFFFFFFF -> TRAP after DECODE, illegal=1, imem_req stays 0 for 20 cycles until rst.
REQ-035 rst asserted during MEM of SW (0x0020A023) -> dmem_req=0 immediately, FETCH with imem_req=1 on the first cycle after release.

Source files
------------

// File: rtl/rv_pkg.sv
// rv_pkg -- shared RV32I control definitions.
//   Opcode constants (instr[6:0]) for the nine legal RV32I major opcodes.
//   imm_sel encoding, shared by the immediate generator and the controller.
//   pc_sel and wb_sel mux encodings.
//   Controller state enum; the encoding is visible on the debug state port.
//   op_class_t is the decoded instruction class.
//   Helper functions map a class to its immediate type and ALU B source.
package rv_pkg;

  // Major opcodes
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // Immediate type selection
  localparam logic [2:0] IMM_U    = 3'd0;
  localparam logic [2:0] IMM_J    = 3'd1;
  localparam logic [2:0] IMM_B    = 3'd2;
  localparam logic [2:0] IMM_I    = 3'd3;
  localparam logic [2:0] IMM_S    = 3'd4;
  localparam logic [2:0] IMM_NONE = 3'd7;

  // Next-PC source
  localparam logic [1:0] PC_PLUS4  = 2'd0;  // pc + 4
  localparam logic [1:0] PC_OFFSET = 2'd1;  // pc + imm
  localparam logic [1:0] PC_JALR   = 2'd2;  // (rs1 + imm) & ~1

  // Register write-back source
  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_LOAD = 2'd1;
  localparam logic [1:0] WB_PC4  = 2'd2;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    CLS_LUI,
    CLS_AUIPC,
    CLS_JAL,
    CLS_JALR,
    CLS_BRANCH,
    CLS_LOAD,
    CLS_STORE,
    CLS_OPIMM,
    CLS_OP,
    CLS_ILLEGAL
  } op_class_t;

  function automatic logic [2:0] imm_sel_of(input op_class_t cls);
    logic [2:0] sel;
    sel = IMM_NONE;
    case (cls)
      CLS_LUI, CLS_AUIPC:           sel = IMM_U;
      CLS_JAL:                      sel = IMM_J;
      CLS_JALR, CLS_LOAD, CLS_OPIMM: sel = IMM_I;
      CLS_BRANCH:                   sel = IMM_B;
      CLS_STORE:                    sel = IMM_S;
      default:                      sel = IMM_NONE;
    endcase
    return sel;
  endfunction

  // Register-register ALU ops and branch compares take rs2; everything
  // else legal feeds the immediate into ALU operand B.
  function automatic logic alu_imm_of(input op_class_t cls);
    return !(cls == CLS_OP || cls == CLS_BRANCH || cls == CLS_ILLEGAL);
  endfunction

endpackage

// File: rtl/opcode_decode.sv
// opcode_decode -- purely combinational opcode classifier.
//   opcode   in  7  instr[6:0]
//   op_class out    decoded class (CLS_ILLEGAL for unknown opcodes)
//   legal    out 1  opcode is one of the nine supported RV32I opcodes
module opcode_decode
  import rv_pkg::*;
(
  input  logic [6:0] opcode,
  output op_class_t  op_class,
  output logic       legal
);

  always_comb begin
    op_class = CLS_ILLEGAL;
    case (opcode)
      OPC_LUI:    op_class = CLS_LUI;
      OPC_AUIPC:  op_class = CLS_AUIPC;
      OPC_JAL:    op_class = CLS_JAL;
      OPC_JALR:   op_class = CLS_JALR;
      OPC_BRANCH: op_class = CLS_BRANCH;
      OPC_LOAD:   op_class = CLS_LOAD;
      OPC_STORE:  op_class = CLS_STORE;
      OPC_OPIMM:  op_class = CLS_OPIMM;
      OPC_OP:     op_class = CLS_OP;
      default:    op_class = CLS_ILLEGAL;
    endcase
  end

  assign legal = (op_class != CLS_ILLEGAL);

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl -- multi-cycle RV32I control FSM.
//   clk         in   core clock (rising edge)
//   rst         in   asynchronous active-high reset, forces FETCH
//   instr       in   fetched word while imem_ready in FETCH, IR contents after
//   imem_req    out  / imem_ready in : instruction fetch handshake
//   dmem_req    out  / dmem_we out / dmem_ready in : data memory handshake
//   br_taken    in   branch comparator result, sampled in EXEC
//   ir_we, pc_we, rf_we   out  register write enables
//   imm_sel     out  immediate type (rv_pkg IMM_*)
//   pc_sel      out  next-PC source (rv_pkg PC_*)
//   wb_sel      out  register write-back source (rv_pkg WB_*)
//   alu_src_b   out  ALU operand B: 0 rs2, 1 immediate
//   retire      out  one pulse per completed instruction, with pc_we
//   illegal     out  sticky illegal-opcode flag (TRAP state)
//   state       out  debug view of the FSM state encoding
module multicycle_ctrl
  import rv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  output logic        imem_req,
  input  logic        imem_ready,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ready,
  input  logic        br_taken,
  output logic        ir_we,
  output logic        pc_we,
  output logic        rf_we,
  output logic [2:0]  imm_sel,
  output logic [1:0]  pc_sel,
  output logic [1:0]  wb_sel,
  output logic        alu_src_b,
  output logic        retire,
  output logic        illegal,
  output logic [2:0]  state
);

  state_t    state_reg;
  state_t    state_next;
  op_class_t op_class;
  logic      op_legal;
  logic [4:0] rd;
  logic      unused_instr_hi;

  // After FETCH the instruction word on instr is the IR, so the class can be
  // decoded combinationally every cycle instead of being latched.
  opcode_decode u_opcode_decode (
    .opcode   (instr[6:0]),
    .op_class (op_class),
    .legal    (op_legal)
  );

  assign rd              = instr[11:7];
  assign unused_instr_hi = ^instr[31:12];
  assign state           = state_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    rf_we      = 1'b0;
    imm_sel    = IMM_NONE;
    pc_sel     = PC_PLUS4;
    wb_sel     = WB_ALU;
    alu_src_b  = 1'b0;
    retire     = 1'b0;
    illegal    = 1'b0;

    case (state_reg)
      ST_FETCH: begin
        // The reset forces this state asynchronously; gating with rst keeps
        // the fetch request low for as long as reset is held.
        imem_req = !rst;
        if (imem_ready && !rst) begin
          ir_we      = 1'b1;
          state_next = ST_DECODE;
        end
      end

      ST_DECODE: begin
        imm_sel    = imm_sel_of(op_class);
        alu_src_b  = alu_imm_of(op_class);
        state_next = op_legal ? ST_EXEC : ST_TRAP;
      end

      ST_EXEC: begin
        imm_sel   = imm_sel_of(op_class);
        alu_src_b = alu_imm_of(op_class);
        if (op_class == CLS_BRANCH) begin
          pc_we      = 1'b1;
          pc_sel     = br_taken ? PC_OFFSET : PC_PLUS4;
          retire     = 1'b1;
          state_next = ST_FETCH;
        end else if (op_class == CLS_LOAD || op_class == CLS_STORE) begin
          state_next = ST_MEM;
        end else begin
          state_next = ST_WB;
        end
      end

      ST_MEM: begin
        imm_sel   = imm_sel_of(op_class);
        alu_src_b = alu_imm_of(op_class);
        dmem_req  = 1'b1;
        dmem_we   = (op_class == CLS_STORE);
        if (dmem_ready) begin
          if (op_class == CLS_STORE) begin
            pc_we      = 1'b1;
            pc_sel     = PC_PLUS4;
            retire     = 1'b1;
            state_next = ST_FETCH;
          end else begin
            state_next = ST_WB;
          end
        end
      end

      ST_WB: begin
        imm_sel    = imm_sel_of(op_class);
        alu_src_b  = alu_imm_of(op_class);
        rf_we      = (rd != 5'd0);
        pc_we      = 1'b1;
        retire     = 1'b1;
        state_next = ST_FETCH;
        case (op_class)
          CLS_JAL:  begin pc_sel = PC_OFFSET; wb_sel = WB_PC4;  end
          CLS_JALR: begin pc_sel = PC_JALR;   wb_sel = WB_PC4;  end
          CLS_LOAD: begin pc_sel = PC_PLUS4;  wb_sel = WB_LOAD; end
          default:  begin pc_sel = PC_PLUS4;  wb_sel = WB_ALU;  end
        endcase
      end

      ST_TRAP: begin
        // Terminal state: only rst leaves it, so the flag is sticky.
        illegal    = 1'b1;
        state_next = ST_TRAP;
      end

      default: begin
        state_next = ST_FETCH;
      end
    endcase
  end

endmodule
